// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module      : serial_subtractor_if
// Description : Start/busy/done handshake bundle for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    // Requester side: issues operands, observes status and result
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    // Subtractor side
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned A - B - BIN, one full-subtractor bit per
//               clock, LSB first, with a held result register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_subtractor_if.slave sif
);

    localparam int            c_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_sr_a;
    logic [WIDTH-1:0]  r_sr_b;
    logic [WIDTH-1:0]  r_sr_d;
    logic              r_borrow;
    logic [c_CW-1:0]   r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_diff;
    logic              r_bout;

    logic              w_x;
    logic              w_y;
    logic              w_d;
    logic              w_borrow_next;
    logic              w_last;
    logic [WIDTH-1:0]  w_result;

    // Single full-subtractor cell operating on the current LSBs
    assign w_x           = r_sr_a[0];
    assign w_y           = r_sr_b[0];
    assign w_d           = w_x ^ w_y ^ r_borrow;
    assign w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
    assign w_last        = (r_cnt == c_LAST);

    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
    assign w_result      = {w_d, r_sr_d[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_sr_a   <= '0;
            r_sr_b   <= '0;
            r_sr_d   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (sif.start) begin
                        r_sr_a   <= sif.a;
                        r_sr_b   <= sif.b;
                        r_sr_d   <= '0;
                        r_borrow <= sif.bin;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_sr_d   <= w_result;
                    r_sr_a   <= r_sr_a >> 1;
                    r_sr_b   <= r_sr_b >> 1;
                    r_borrow <= w_borrow_next;
                    r_cnt    <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        // Only the completed word is ever published
                        r_diff  <= w_result;
                        r_bout  <= w_borrow_next;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sif.busy = r_busy;
    assign sif.done = r_done;
    assign sif.diff = r_diff;
    assign sif.bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed-vector scoreboard bench for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH:0]   mon_e;
    logic [WIDTH-1:0] last_diff;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse consumes one expected {bout, diff}
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sif.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("diff", {24'd0, sif.diff}, {24'd0, mon_e[WIDTH-1:0]});
                check("bout", {31'd0, sif.bout}, {31'd0, mon_e[WIDTH]});
            end
        end
    end

    // mode 0: plain; mode 1: start pulses during SHIFT and on the done cycle;
    // mode 2: operand inputs scrambled every cycle while in flight
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input logic [WIDTH-1:0] exp_d,
                          input logic exp_bo, input int mode);
        int busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen     = 1'b0;
        @(negedge clk);
        sif.a     = a;
        sif.b     = b;
        sif.bin   = bin;
        sif.start = 1'b1;
        exp_q.push_back({exp_bo, exp_d});
        @(posedge clk);
        #1 sif.start = 1'b0;
        for (int k = 1; k <= WIDTH + 4 && !seen; k++) begin
            @(negedge clk);
            if (sif.busy === 1'b1) busy_cnt++;
            if (sif.done === 1'b1) begin
                seen = 1'b1;
                check("done_latency", k, WIDTH + 1);
            end else begin
                check("diff_hold", {24'd0, sif.diff}, {24'd0, last_diff});
            end
            if (mode == 1) begin
                sif.start = (k == 3) || (sif.done === 1'b1);
                sif.a     = 8'h01;
                sif.b     = 8'h02;
                sif.bin   = 1'b0;
            end else if (mode == 2) begin
                sif.a   = 8'($urandom);
                sif.b   = 8'($urandom);
                sif.bin = 1'($urandom);
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        check("busy_cycles", busy_cnt, WIDTH + 1);
        @(negedge clk);
        sif.start = 1'b0;
        check("done_one_cycle", {31'd0, sif.done}, 32'd0);
        check("busy_dropped", {31'd0, sif.busy}, 32'd0);
        check("diff_after_done", {24'd0, sif.diff}, {24'd0, exp_d});
        last_diff = exp_d;
    endtask

    initial begin
        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        sif.bin   = 1'b0;
        last_diff = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, sif.busy}, 32'd0);
        check("rst_done", {31'd0, sif.done}, 32'd0);
        check("rst_diff", {24'd0, sif.diff}, 32'd0);
        check("rst_bout", {31'd0, sif.bout}, 32'd0);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 0);
        run_op(8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 0);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0);
        run_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 0);
        run_op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 0);
        run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 0);

        // Starts while busy must be dropped, not queued
        run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1);
        for (int i = 0; i < WIDTH + 3; i++) begin
            @(negedge clk);
            check("ignored_start_idle", {31'd0, sif.busy}, 32'd0);
        end
        run_op(8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 0);

        run_op(8'hC3, 8'h3C, 1'b1, 8'h86, 1'b0, 2);

        // Reset in the middle of an operation
        @(negedge clk);
        sif.a     = 8'h5A;
        sif.b     = 8'h3C;
        sif.bin   = 1'b0;
        sif.start = 1'b1;
        @(posedge clk);
        #1 sif.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, sif.busy}, 32'd0);
        check("abort_done", {31'd0, sif.done}, 32'd0);
        check("abort_diff", {24'd0, sif.diff}, 32'd0);
        check("abort_bout", {31'd0, sif.bout}, 32'd0);
        rst_n = 1'b1;
        last_diff = '0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, sif.done}, 32'd0);
        end
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor computing DIFF = A - B - BIN, one bit per clock, LSB first.
- Each bit uses a single full-subtractor cell; the borrow is carried between bits in a flip-flop.
- Sits beside the combinational adder/subtractor cells as the area-cheap sequential arithmetic unit.
- Uses a start/busy/done handshake with a held result register.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while an operation is in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result; held until the next done.
- bout  output  1  final borrow-out (1 when A < B + BIN); held with diff.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset (rst_n low at a clk edge) forces:
  - state to IDLE;
  - busy=0, done=0, diff=0, bout=0;
  - internal shift registers, bit counter and borrow flip-flop to 0.
- Reset has priority over every other event and aborts an operation mid-way.
- No partial result is ever published.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: capture a, b into shift registers; load borrow FF with bin; clear counter; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1): at each edge, with x = sr_a[0], y = sr_b[0], c = borrow FF:
  - d = x ^ y ^ c.
  - borrow_next = (~x & y) | (~(x ^ y) & c).
  - Shift d into the result shift register from the MSB end.
  - Shift sr_a and sr_b right by one.
  - Borrow FF <= borrow_next; counter += 1.
  - On the edge processing bit WIDTH-1: copy the full result into diff, borrow_next into bout, go to DONE.
- DONE: busy=1, done=1 for exactly one cycle; next edge goes to IDLE.
- Timing:
  - Start accepted at edge 0.
  - Bits are processed at edges 1..WIDTH.
  - done is high during the cycle following edge WIDTH.
  - busy drops after edge WIDTH+1.
  - Earliest next accept is edge WIDTH+2.
- start while busy=1 (SHIFT or DONE, including the done cycle) is ignored. No queuing, no error flag.
- a, b, bin may change freely after capture; they do not affect an operation in flight.
- diff/bout:
  - change only at the edge entering DONE;
  - stay stable through IDLE and the following SHIFT until the next done.
- Arithmetic is modulo 2^WIDTH.
- bout equals the borrow out of the MSB, i.e. 1 iff a < b + bin as unsigned values.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse -> done exactly 9 cycles after the start edge; diff=0x1E, bout=0; busy high for 9 cycles.
- a=0x3C, b=0x5A, bin=0 -> diff=0xE2, bout=1. Then a=0x00, b=0x01 -> diff=0xFF, bout=1.
- Borrow-in and boundaries:
  - a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
  - a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
  - a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0.
- a=0x5A, b=0x3C accepted; start asserted with a=0x01, b=0x02 on cycles 3 and 9 (the done cycle) -> both ignored; diff=0x1E. A start after returning to IDLE is accepted normally.
- Reset mid-operation: a=0x5A, b=0x3C started, rst_n low at cycle 4 -> next cycle busy=0, done=0, diff=0x00, bout=0; no done pulse follows. A new operation a=0x05, b=0x03 then gives diff=0x02, bout=0.
- Changing a/b/bin every cycle during SHIFT does not alter the result. diff holds its old value during a following operation until that operation's done.
